// File: rtl/alu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_arb_pkg
// Brief    : Shared widths, FSM state type and opcode helper for alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package alu_arb_pkg;

  localparam int OPW   = 8;
  localparam int SELW  = 3;
  localparam int ADDRW = 4;
  localparam int RESW  = 9;
  localparam int CNTW  = 16;

  localparam logic [SELW-1:0] SEL_MAX = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic sel_illegal(input logic [SELW-1:0] sel);
    return (sel > SEL_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant; pointer names the favoured requester.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       pointer,
  input  logic       advance,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (advance) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = pointer ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin sharing of one ALU between two requesters, with the
//            result written to a result memory. Define ALU_ARB_STATS_EN to add
//            saturating per-requester grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_a,
  input  logic [OPW-1:0]   req0_b,
  input  logic [SELW-1:0]  req0_sel,
  input  logic [ADDRW-1:0] req0_addr,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_a,
  input  logic [OPW-1:0]   req1_b,
  input  logic [SELW-1:0]  req1_sel,
  input  logic [ADDRW-1:0] req1_addr,
  output logic [OPW-1:0]   alu_a,
  output logic [OPW-1:0]   alu_b,
  output logic [SELW-1:0]  alu_sel,
  input  logic [RESW-1:0]  alu_c,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [RESW-1:0]  mem_wdata,
  output logic             done0,
  output logic             done1,
  output logic             err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNTW-1:0]  gnt_cnt0,
  output logic [CNTW-1:0]  gnt_cnt1
`endif
);

  localparam int             LATW     = 3;
  localparam logic [LATW-1:0] LAST_CYC = LATW'(ALU_LAT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             r_who;
  logic [OPW-1:0]   r_a;
  logic [OPW-1:0]   r_b;
  logic [SELW-1:0]  r_sel;
  logic [ADDRW-1:0] r_addr;
  logic [RESW-1:0]  r_res;
  logic [LATW-1:0]  r_lat_cnt;

  logic [1:0]       w_grant;
  logic             w_advance;
  logic             w_accept;
  logic             w_last_exec;

  // Grants only in IDLE and never while reset is held, so ready is 0 under rst.
  assign w_advance   = (r_state == IDLE) && !rst;
  assign w_accept    = |w_grant;
  assign w_last_exec = (r_state == EXEC) && (r_lat_cnt == LAST_CYC);

  rr_arb2 u_rr_arb2 (
    .valid   ({req1_valid, req0_valid}),
    .pointer (r_ptr),
    .advance (w_advance),
    .grant   (w_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = EXEC;
      EXEC:    if (w_last_exec) w_state_nxt = WRITE;
      WRITE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = w_grant[0];
    req1_ready = w_grant[1];
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    done0      = 1'b0;
    done1      = 1'b0;
    err        = 1'b0;
    if (r_state == WRITE) begin
      mem_we    = 1'b1;
      mem_addr  = r_addr;
      mem_wdata = r_res;
      done0     = !r_who;
      done1     = r_who;
      err       = sel_illegal(r_sel);
    end
  end

  // The operand latches double as the ALU drive: they change only on accept,
  // so the ALU sees the new operation from the first EXEC cycle and holds it.
  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_sel = r_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr     <= 1'b0;
      r_who     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_res     <= '0;
      r_lat_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_ptr     <= w_grant[0];
        r_who     <= w_grant[1];
        r_a       <= w_grant[1] ? req1_a    : req0_a;
        r_b       <= w_grant[1] ? req1_b    : req0_b;
        r_sel     <= w_grant[1] ? req1_sel  : req0_sel;
        r_addr    <= w_grant[1] ? req1_addr : req0_addr;
        r_lat_cnt <= '0;
      end else if ((r_state == EXEC) && !w_last_exec) begin
        r_lat_cnt <= r_lat_cnt + LATW'(1);
      end
      if (w_last_exec) begin
        r_res <= alu_c;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNTW-1:0] r_gnt_cnt0;
  logic [CNTW-1:0] r_gnt_cnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else begin
      if (w_grant[0] && (r_gnt_cnt0 != '1)) r_gnt_cnt0 <= r_gnt_cnt0 + CNTW'(1);
      if (w_grant[1] && (r_gnt_cnt1 != '1)) r_gnt_cnt1 <= r_gnt_cnt1 + CNTW'(1);
    end
  end

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed bench for alu_arbiter at ALU_LAT=1 and ALU_LAT=4 against
//            a transaction-level schedule model. Honours ALU_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v0, v1;
  logic [7:0] a0, b0, a1, b1;
  logic [2:0] s0, s1;
  logic [3:0] ad0, ad1;

  logic [1:0] rdy0, rdy1, we, dn0, dn1, er;
  logic [7:0] alu_a [2];
  logic [7:0] alu_b [2];
  logic [2:0] alu_s [2];
  logic [8:0] alu_c [2];
  logic [3:0] maddr [2];
  logic [8:0] mdata [2];
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gc0 [2];
  logic [15:0] gc1 [2];
`endif

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.ALU_LAT(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(rdy0[0]), .req0_a(a0), .req0_b(b0), .req0_sel(s0), .req0_addr(ad0),
    .req1_valid(v1), .req1_ready(rdy1[0]), .req1_a(a1), .req1_b(b1), .req1_sel(s1), .req1_addr(ad1),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_sel(alu_s[0]), .alu_c(alu_c[0]),
    .mem_we(we[0]), .mem_addr(maddr[0]), .mem_wdata(mdata[0]),
    .done0(dn0[0]), .done1(dn1[0]), .err(er[0])
`ifdef ALU_ARB_STATS_EN
    , .gnt_cnt0(gc0[0]), .gnt_cnt1(gc1[0])
`endif
  );

  alu_arbiter #(.ALU_LAT(LAT_B)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(rdy0[1]), .req0_a(a0), .req0_b(b0), .req0_sel(s0), .req0_addr(ad0),
    .req1_valid(v1), .req1_ready(rdy1[1]), .req1_a(a1), .req1_b(b1), .req1_sel(s1), .req1_addr(ad1),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_sel(alu_s[1]), .alu_c(alu_c[1]),
    .mem_we(we[1]), .mem_addr(maddr[1]), .mem_wdata(mdata[1]),
    .done0(dn0[1]), .done1(dn1[1]), .err(er[1])
`ifdef ALU_ARB_STATS_EN
    , .gnt_cnt0(gc0[1]), .gnt_cnt1(gc1[1])
`endif
  );

  // External ALU; opcodes 6 and 7 return fixed marker values.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a, 1'b0};
      3'd6:    return 9'h1A5;
      default: return 9'h0F0;
    endcase
  endfunction

  // The slow ALU shows a result only LAT_B cycles after its operands appear.
  logic [8:0] pipe [3] = '{9'h0, 9'h0, 9'h0};
  always @(posedge clk) begin
    pipe[0] <= alu_f(alu_a[1], alu_b[1], alu_s[1]);
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign alu_c[0] = alu_f(alu_a[0], alu_b[0], alu_s[0]);
  assign alu_c[1] = pipe[2];

  task automatic chk(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, inst, act, exp);
    end
  endtask

  // Schedule model: an accept at cycle t books the ALU until t+LAT+2 and
  // schedules one result write at t+LAT+1.
  int          cyc = 0;
  int          lat [2]     = '{LAT_A, LAT_B};
  int          free_at [2] = '{0, 0};
  int          wcyc [2]    = '{0, 0};
  bit          prio [2]    = '{1'b0, 1'b0};
  bit          pend [2]    = '{1'b0, 1'b0};
  bit          pwho [2]    = '{1'b0, 1'b0};
  bit          perr [2]    = '{1'b0, 1'b0};
  logic [3:0]  paddr [2]   = '{4'h0, 4'h0};
  logic [8:0]  pres [2]    = '{9'h0, 9'h0};
  logic [7:0]  cur_a [2]   = '{8'h0, 8'h0};
  logic [7:0]  cur_b [2]   = '{8'h0, 8'h0};
  logic [2:0]  cur_s [2]   = '{3'h0, 3'h0};
  logic [15:0] mcnt [2][2] = '{'{16'h0, 16'h0}, '{16'h0, 16'h0}};

  always @(negedge clk) begin
    bit acc, w, wr;
    for (int i = 0; i < 2; i++) begin
      acc = 1'b0;
      w   = 1'b0;
      wr  = 1'b0;
      if (!rst) begin
        acc = (cyc >= free_at[i]) && (v0 || v1);
        w   = (v0 && v1) ? prio[i] : v1;
        wr  = pend[i] && (wcyc[i] == cyc);
      end
      chk("ready0", i, rdy0[i], acc && !w);
      chk("ready1", i, rdy1[i], acc && w);
      chk("mem_we", i, we[i], wr);
      chk("mem_addr", i, maddr[i], wr ? paddr[i] : 4'h0);
      chk("mem_wdata", i, mdata[i], wr ? pres[i] : 9'h0);
      chk("done0", i, dn0[i], wr && !pwho[i]);
      chk("done1", i, dn1[i], wr && pwho[i]);
      chk("err", i, er[i], wr && perr[i]);
      chk("alu_a", i, alu_a[i], rst ? 8'h0 : cur_a[i]);
      chk("alu_b", i, alu_b[i], rst ? 8'h0 : cur_b[i]);
      chk("alu_sel", i, alu_s[i], rst ? 3'h0 : cur_s[i]);
`ifdef ALU_ARB_STATS_EN
      chk("gnt_cnt0", i, gc0[i], rst ? 16'h0 : mcnt[i][0]);
      chk("gnt_cnt1", i, gc1[i], rst ? 16'h0 : mcnt[i][1]);
`endif
      if (rst) begin
        pend[i]    = 1'b0;
        prio[i]    = 1'b0;
        cur_a[i]   = 8'h0;
        cur_b[i]   = 8'h0;
        cur_s[i]   = 3'h0;
        free_at[i] = cyc + 1;
        mcnt[i][0] = 16'h0;
        mcnt[i][1] = 16'h0;
      end else begin
        if (wr) pend[i] = 1'b0;
        if (acc) begin
          pend[i]    = 1'b1;
          wcyc[i]    = cyc + lat[i] + 1;
          free_at[i] = cyc + lat[i] + 2;
          pwho[i]    = w;
          prio[i]    = !w;
          cur_a[i]   = w ? a1 : a0;
          cur_b[i]   = w ? b1 : b0;
          cur_s[i]   = w ? s1 : s0;
          paddr[i]   = w ? ad1 : ad0;
          pres[i]    = alu_f(cur_a[i], cur_b[i], cur_s[i]);
          perr[i]    = (cur_s[i] > 3'd5);
          if (mcnt[i][w] != 16'hFFFF) mcnt[i][w] = mcnt[i][w] + 16'h1;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int q_who_a [$];
  int q_cyc_a [$];
  int q_cyc_b [$];

  initial begin
    rst = 1'b1;
    v0 = 1'b1; a0 = 8'd5; b0 = 8'd136; s0 = 3'd0; ad0 = 4'd0;
    v1 = 1'b0; a1 = 8'd0; b1 = 8'd0;   s1 = 3'd0; ad1 = 4'd0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_ready0", 0, rdy0[0], 1'b0);
    chk("rst_mem_we", 1, we[1], 1'b0);
    chk("rst_alu_a", 0, alu_a[0], 8'h0);

    // Single req0 on the 1-cycle ALU: write of 5+136 two cycles after accept.
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("acc_ready0", 0, rdy0[0], 1'b1);
    tick(); v0 = 1'b0;
    @(negedge clk);
    chk("exec_mem_we", 0, we[0], 1'b0);
    tick();
    @(negedge clk);
    chk("wr_mem_we", 0, we[0], 1'b1);
    chk("wr_wdata", 0, mdata[0], 9'd141);
    chk("wr_done0", 0, dn0[0], 1'b1);
    chk("wr_addr", 0, maddr[0], 4'd0);
    repeat (6) tick();

    // Both requesters continuously valid.
    do_reset();
    v0 = 1'b1; a0 = 8'd10;  b0 = 8'd3;   s0 = 3'd1; ad0 = 4'd1;
    v1 = 1'b1; a1 = 8'h0F;  b1 = 8'hF0;  s1 = 3'd3; ad1 = 4'd2;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (rdy0[0]) begin q_who_a.push_back(0); q_cyc_a.push_back(k); end
      if (rdy1[0]) begin q_who_a.push_back(1); q_cyc_a.push_back(k); end
      if (rdy0[1] || rdy1[1]) q_cyc_b.push_back(k);
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("alt_count", 0, 16'(q_who_a.size() >= 4), 16'h1);
    for (int k = 0; k < 4 && k < q_who_a.size(); k++) begin
      chk("alt_who", 0, 16'(q_who_a[k]), 16'(k % 2));
      if (k > 0) chk("alt_gap", 0, 16'(q_cyc_a[k] - q_cyc_a[k-1]), 16'd3);
    end
    chk("alt_count", 1, 16'(q_cyc_b.size() >= 2), 16'h1);
    if (q_cyc_b.size() >= 2) chk("alt_gap", 1, 16'(q_cyc_b[1] - q_cyc_b[0]), 16'd6);
    repeat (8) tick();

    // req1 twice alone, then both: req0 must win.
    do_reset();
    v1 = 1'b1; a1 = 8'd100; b1 = 8'd50; s1 = 3'd1; ad1 = 4'd3;
    @(negedge clk);
    chk("solo1_ready1", 0, rdy1[0], 1'b1);
    tick(); v1 = 1'b0;
    repeat (7) tick();
    v1 = 1'b1; a1 = 8'd7; b1 = 8'd9; s1 = 3'd2; ad1 = 4'd4;
    @(negedge clk);
    chk("solo2_ready1", 1, rdy1[1], 1'b1);
    tick(); v1 = 1'b0;
    repeat (7) tick();
    v0 = 1'b1; a0 = 8'd200; b0 = 8'd100; s0 = 3'd0; ad0 = 4'd5;
    v1 = 1'b1;
    @(negedge clk);
    chk("third_ready0", 0, rdy0[0], 1'b1);
    chk("third_ready1", 0, rdy1[0], 1'b0);
    chk("third_ready0", 1, rdy0[1], 1'b1);
    tick(); v0 = 1'b0; v1 = 1'b0;
    tick();
    @(negedge clk);
    chk("carry_wdata", 0, mdata[0], 9'h12C);
    repeat (7) tick();

    // Illegal opcode from req1 still writes and flags err with done1.
    v1 = 1'b1; a1 = 8'd1; b1 = 8'd2; s1 = 3'd7; ad1 = 4'd9;
    @(negedge clk);
    chk("ill_ready1", 0, rdy1[0], 1'b1);
    tick(); v1 = 1'b0;
    tick();
    @(negedge clk);
    chk("ill_mem_we", 0, we[0], 1'b1);
    chk("ill_done1", 0, dn1[0], 1'b1);
    chk("ill_err", 0, er[0], 1'b1);
    chk("ill_addr", 0, maddr[0], 4'd9);
    chk("ill_wdata", 0, mdata[0], 9'h0F0);
    repeat (7) tick();

    // Reset in the middle of the 4-cycle EXEC.
    v0 = 1'b1; a0 = 8'h33; b0 = 8'h11; s0 = 3'd4; ad0 = 4'd6;
    tick(); v0 = 1'b0;
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("abort_mem_we", 1, we[1], 1'b0);
    chk("abort_done0", 1, dn0[1], 1'b0);
    chk("abort_alu_a", 1, alu_a[1], 8'h0);
    tick();
    tick(); rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1; a0 = 8'd4; b0 = 8'd4; s0 = 3'd0; ad0 = 4'd7;
    @(negedge clk);
    chk("post_rst_ready0", 1, rdy0[1], 1'b1);
    chk("post_rst_ready1", 1, rdy1[1], 1'b0);
    tick(); v0 = 1'b0; v1 = 1'b0;
    repeat (8) tick();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 4; k++) begin
      v0 = (k != 3); v1 = (k == 3);
      tick(); v0 = 1'b0; v1 = 1'b0;
      repeat (7) tick();
    end
    @(negedge clk);
    chk("stats_cnt0", 0, gc0[0], 16'd3);
    chk("stats_cnt1", 0, gc1[0], 16'd1);
    tick();
    force u_dut_a.r_gnt_cnt0 = 16'hFFFE;
    mcnt[0][0] = 16'hFFFE;
    tick();
    release u_dut_a.r_gnt_cnt0;
    for (int k = 0; k < 2; k++) begin
      v0 = 1'b1;
      tick(); v0 = 1'b0;
      repeat (7) tick();
    end
    @(negedge clk);
    chk("stats_sat", 0, gc0[0], 16'hFFFF);
    tick();
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter ALU_LAT, default 1: ALU latency in cycles from operand drive to valid alu_c, legal range 1..8.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 reqN_a, reqN_b  input  8  operands, unsigned, carried to the ALU unchanged.
REQ-007 reqN_sel  input  3  ALU opcode; legal values 0..5.
REQ-008 reqN_addr  input  4  destination result-memory address.
REQ-009 alu_a, alu_b  output  8  and alu_sel  output  3: shared ALU operand and opcode drive.
REQ-010 alu_c  input  9  ALU result, including carry or sign bit 8.
REQ-011 mem_we  output  1, mem_addr  output  4, mem_wdata  output  9: result-memory write port.
REQ-012 done0 / done1  output  1  one-cycle pulse when requester N's result is written.
REQ-013 err  output  1  one-cycle pulse with done when the executed sel is 6 or 7.

Function
REQ-014 States SHALL be IDLE, EXEC and WRITE.
REQ-015 IDLE: if any valid is high, the winner SHALL get ready=1 combinationally, its fields SHALL be latched, the FSM SHALL go to EXEC, and the round-robin pointer SHALL update.
REQ-016 Arbitration: a single valid wins; with both valid, the requester not granted last wins; the pointer after reset favours req0.
REQ-017 Ready SHALL be 0 in EXEC and WRITE, and at most one ready SHALL be high per cycle.
REQ-018 EXEC: alu_a, alu_b and alu_sel SHALL drive the latched values for exactly ALU_LAT cycles; alu_c SHALL be captured on the last of these cycles; the FSM SHALL then go to WRITE.
REQ-019 WRITE: mem_we=1, mem_addr=latched addr, mem_wdata=captured alu_c, and done of the granted requester =1, all for one cycle; the FSM SHALL then go to IDLE.
REQ-020 Latency: accept at cycle T gives mem_we/done at T+ALU_LAT+1; the next accept occurs no earlier than T+ALU_LAT+2.
REQ-021 Illegal sel 6 or 7 SHALL still execute and be written, with err pulsed alongside done.
REQ-022 Valid deasserting during EXEC or WRITE SHALL NOT affect the operation in flight.
REQ-023 A losing requester SHALL keep its fields stable while valid is high; the block does not buffer them.
REQ-024 Outside EXEC, alu_* SHALL hold their last driven values; mem_* SHALL be 0 outside WRITE.

Reset
REQ-025 rst SHALL force IDLE, pointer to favour req0, all ready/done/err/mem_we to 0, and alu_*, mem_addr, mem_wdata and the latches to 0, immediately and asynchronously.
REQ-026 rst asserted mid-EXEC or mid-WRITE SHALL abort the operation with no write and no done.

Configuration
REQ-027 With ALU_ARB_STATS_EN defined, the block SHALL add outputs gnt_cnt0 and gnt_cnt1 (16 bits each), incrementing on each accept for that requester, saturating at 0xFFFF, and reset to 0.
REQ-028 With ALU_ARB_STATS_EN undefined, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 Package alu_arb_pkg SHALL hold: the state enum (IDLE/EXEC/WRITE), OPW=8, SELW=3, ADDRW=4, RESW=9, and SEL_MAX=5.
REQ-030 Sub-module rr_arb2 SHALL be the 2-way round-robin grant logic: inputs valid[1:0], pointer and advance; output grant[1:0].

Verification
REQ-031 req0 alone with a=5, b=136, sel=0, addr=0, ALU_LAT=1 -> ready0 at T; mem_we, addr 0, wdata 141 and done0 at T+2.
REQ-032 req0 and req1 both valid continuously -> grants alternate 0,1,0,1; each accept is ALU_LAT+2 cycles apart.
REQ-033 req1 alone twice, then both valid -> req0 wins the third grant.
REQ-034 sel=7 from req1 -> write occurs, and done1 and err pulse in the same cycle.
REQ-035 rst asserted during EXEC with ALU_LAT=4 -> no mem_we and no done; outputs are 0 immediately; after release, req0 wins a simultaneous request.
REQ-036 ALU_ARB_STATS_EN defined, 3 accepts by req0 and 1 by req1 -> gnt_cnt0=3, gnt_cnt1=1; counter forced near 0xFFFF saturates.
